// File: rtl/branch_resolve_unit.sv
// Branch resolve stage: compares r1 against r0 for the decoded condition, registers the
// outcome one cycle later, and trains a table of 2-bit saturating branch-history counters.
module branch_resolve_unit #(
    parameter int WIDTH      = 16,
    parameter int BHT_BITS   = 4,
    parameter int SIGNED_CMP = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [3:0]          opCode,
    input  logic [WIDTH-1:0]    r0,
    input  logic [WIDTH-1:0]    r1,
    input  logic [BHT_BITS-1:0] in_idx,
    input  logic                in_pred,
    input  logic                stall,
    input  logic                flush,
    input  logic [BHT_BITS-1:0] pred_idx,
    output logic                pred_taken,
    output logic                res_valid,
    output logic [1:0]          branch,
    output logic                mispredict,
    output logic [15:0]         br_count,
    output logic [15:0]         mp_count
);

    localparam int ENTRIES = 1 << BHT_BITS;

    logic [1:0]  r_bht [ENTRIES];
    logic        r_res_valid;
    logic [1:0]  r_branch;
    logic        r_mispredict;
    logic [15:0] r_br_count;
    logic [15:0] r_mp_count;

    logic        w_eq;
    logic        w_gt;
    logic        w_lt;
    logic        w_is_branch;
    logic        w_taken;
    logic        w_accept;
    logic        w_update;
    logic        w_mispredict;
    logic [1:0]  w_bht_cur;
    logic [1:0]  w_bht_next;

    // Handshake: a request is taken when in_valid=1 and stall=0 (no ready output; stall is the
    // back-pressure). flush overrides everything and only clears res_valid.
    assign w_accept = in_valid && !stall && !flush;
    assign w_update = w_accept && w_is_branch;

    always_comb begin
        w_eq = (r1 == r0);
        if (SIGNED_CMP != 0) begin
            w_gt = ($signed(r1) > $signed(r0));
            w_lt = ($signed(r1) < $signed(r0));
        end else begin
            w_gt = (r1 > r0);
            w_lt = (r1 < r0);
        end
    end

    always_comb begin
        w_is_branch = 1'b1;
        w_taken     = 1'b0;
        case (opCode)
            4'b0110: w_taken = w_eq;
            4'b0111: w_taken = !w_eq;
            4'b0100: w_taken = w_gt;
            4'b0101: w_taken = w_lt;
            4'b1000: w_taken = !w_lt;
            4'b1001: w_taken = !w_gt;
            default: w_is_branch = 1'b0;
        endcase
    end

    assign w_mispredict = w_is_branch && (w_taken != in_pred);

    always_comb begin
        w_bht_cur  = r_bht[in_idx];
        w_bht_next = w_bht_cur;
        if (w_taken) begin
            if (w_bht_cur != 2'b11) w_bht_next = w_bht_cur + 2'b01;
        end else begin
            if (w_bht_cur != 2'b00) w_bht_next = w_bht_cur - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_update) begin
            r_bht[in_idx] <= w_bht_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid  <= 1'b0;
            r_branch     <= 2'b01;
            r_mispredict <= 1'b0;
            r_br_count   <= 16'd0;
            r_mp_count   <= 16'd0;
        end else if (flush) begin
            r_res_valid <= 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                r_res_valid  <= 1'b1;
                r_branch     <= (w_is_branch && w_taken) ? 2'b00 : 2'b01;
                r_mispredict <= w_mispredict;
                if (w_is_branch) begin
                    if (r_br_count != 16'hFFFF) r_br_count <= r_br_count + 16'd1;
                    if (w_mispredict && (r_mp_count != 16'hFFFF)) r_mp_count <= r_mp_count + 16'd1;
                end
            end else begin
                r_res_valid <= 1'b0;
            end
        end
    end

    // Reads the registered table, so an update in flight is not visible until after the edge.
    assign pred_taken = r_bht[pred_idx][1];
    assign res_valid  = r_res_valid;
    assign branch     = r_branch;
    assign mispredict = r_mispredict;
    assign br_count   = r_br_count;
    assign mp_count   = r_mp_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: an unsigned and a signed instance share stimulus and are
// checked against a per-instance behavioural model of the BHT, counters and result register.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  opCode;
  logic [15:0] r0;
  logic [15:0] r1;
  logic [3:0]  in_idx;
  logic        in_pred;
  logic        stall;
  logic        flush;
  logic [3:0]  pred_idx;
  logic [1:0]  pt;
  logic [1:0]  rv;
  logic [1:0]  br [2];
  logic [1:0]  mp;
  logic [15:0] bc [2];
  logic [15:0] mc [2];

  int n_checks = 0;
  int n_pass = 0;

  // model state, index 0 = unsigned instance, 1 = signed instance
  int m_bht [2][16];
  int m_bc [2];
  int m_mc [2];
  bit m_rv [2];
  int m_brout [2];
  bit m_mpout [2];

  branch_resolve_unit #(.WIDTH(16), .BHT_BITS(4), .SIGNED_CMP(0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opCode(opCode), .r0(r0), .r1(r1),
    .in_idx(in_idx), .in_pred(in_pred), .stall(stall), .flush(flush), .pred_idx(pred_idx),
    .pred_taken(pt[0]), .res_valid(rv[0]), .branch(br[0]), .mispredict(mp[0]),
    .br_count(bc[0]), .mp_count(mc[0]));

  branch_resolve_unit #(.WIDTH(16), .BHT_BITS(4), .SIGNED_CMP(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opCode(opCode), .r0(r0), .r1(r1),
    .in_idx(in_idx), .in_pred(in_pred), .stall(stall), .flush(flush), .pred_idx(pred_idx),
    .pred_taken(pt[1]), .res_valid(rv[1]), .branch(br[1]), .mispredict(mp[1]),
    .br_count(bc[1]), .mp_count(mc[1]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_br(input logic [3:0] op);
    return (op == 4'b0110) || (op == 4'b0111) || (op == 4'b0100) ||
           (op == 4'b0101) || (op == 4'b1000) || (op == 4'b1001);
  endfunction

  function automatic bit mdl_taken(input logic [3:0] op, input logic [15:0] a0,
                                   input logic [15:0] a1, input bit sgn);
    int x0;
    int x1;
    x0 = sgn ? int'($signed(a0)) : int'(a0);
    x1 = sgn ? int'($signed(a1)) : int'(a1);
    case (op)
      4'b0110: return x1 == x0;
      4'b0111: return x1 != x0;
      4'b0100: return x1 > x0;
      4'b0101: return x1 < x0;
      4'b1000: return x1 >= x0;
      4'b1001: return x1 <= x0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic mdl_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) m_bht[d][i] = 1;
      m_bc[d] = 0;
      m_mc[d] = 0;
      m_rv[d] = 0;
      m_brout[d] = 1;
      m_mpout[d] = 0;
    end
  endtask

  // driver tasks
  task automatic drive(input bit v, input logic [3:0] op, input logic [15:0] a0,
                       input logic [15:0] a1, input logic [3:0] idx, input bit p,
                       input bit st, input bit fl);
    in_valid = v;
    opCode = op;
    r0 = a0;
    r1 = a1;
    in_idx = idx;
    in_pred = p;
    stall = st;
    flush = fl;
  endtask

  // advances the model by the inputs now applied, then clocks the DUTs
  task automatic do_cycle();
    bit t;
    for (int d = 0; d < 2; d++) begin
      if (flush) begin
        m_rv[d] = 0;
      end else if (!stall) begin
        if (!in_valid) begin
          m_rv[d] = 0;
        end else if (is_br(opCode)) begin
          t = mdl_taken(opCode, r0, r1, d == 1);
          m_rv[d] = 1;
          m_brout[d] = t ? 0 : 1;
          m_mpout[d] = (t != in_pred);
          if (t) m_bht[d][in_idx] = (m_bht[d][in_idx] < 3) ? m_bht[d][in_idx] + 1 : 3;
          else   m_bht[d][in_idx] = (m_bht[d][in_idx] > 0) ? m_bht[d][in_idx] - 1 : 0;
          m_bc[d] = (m_bc[d] < 65535) ? m_bc[d] + 1 : 65535;
          if (t != in_pred) m_mc[d] = (m_mc[d] < 65535) ? m_mc[d] + 1 : 65535;
        end else begin
          m_rv[d] = 1;
          m_brout[d] = 1;
          m_mpout[d] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 4'b0000, 16'd0, 16'd0, 4'd0, 0, 0, 0);
    pred_idx = 4'd0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (rv[d] !== 1'b0) $display("FAIL reset_res_valid dut%0d got %b want 0", d, rv[d]); else n_pass++;
      n_checks++;
      if (br[d] !== 2'b01) $display("FAIL reset_branch dut%0d got %b want 01", d, br[d]); else n_pass++;
      n_checks++;
      if (mp[d] !== 1'b0) $display("FAIL reset_mispredict dut%0d got %b want 0", d, mp[d]); else n_pass++;
      n_checks++;
      if (bc[d] !== 16'd0 || mc[d] !== 16'd0)
        $display("FAIL reset_counters dut%0d got %0d/%0d want 0/0", d, bc[d], mc[d]);
      else n_pass++;
    end
    for (int i = 0; i < 16; i++) begin
      pred_idx = 4'(i);
      #1;
      n_checks++;
      if (pt !== 2'b00) $display("FAIL reset_pred_taken idx%0d got %b want 00", i, pt); else n_pass++;
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_beq_directed();
    drive(1, 4'b0110, 16'd5, 16'd5, 4'd3, 0, 0, 0);
    do_cycle();
    drive(0, 4'b0000, 16'd0, 16'd0, 4'd0, 0, 0, 0);
    pred_idx = 4'd3;
    #1;
    n_checks++;
    if (rv[0] !== 1'b1 || br[0] !== 2'b00 || mp[0] !== 1'b1)
      $display("FAIL beq_result got v=%b br=%b mp=%b want v=1 br=00 mp=1", rv[0], br[0], mp[0]);
    else n_pass++;
    n_checks++;
    if (bc[0] !== 16'd1 || mc[0] !== 16'd1)
      $display("FAIL beq_counters got %0d/%0d want 1/1", bc[0], mc[0]);
    else n_pass++;
    n_checks++;
    if (pt[0] !== 1'b1) $display("FAIL beq_bht3 got %b want 1", pt[0]); else n_pass++;
    do_cycle();
    n_checks++;
    if (rv !== 2'b00) $display("FAIL idle_res_valid got %b want 00", rv); else n_pass++;
  endtask

  task automatic test_signed_cmp();
    drive(1, 4'b0101, 16'd1, 16'hFFFF, 4'd5, 0, 0, 0);
    do_cycle();
    drive(0, 4'b0000, 16'd0, 16'd0, 4'd0, 0, 0, 0);
    n_checks++;
    if (br[0] !== 2'b01 || mp[0] !== 1'b0)
      $display("FAIL blt_unsigned got br=%b mp=%b want br=01 mp=0", br[0], mp[0]);
    else n_pass++;
    n_checks++;
    if (br[1] !== 2'b00 || mp[1] !== 1'b1)
      $display("FAIL blt_signed got br=%b mp=%b want br=00 mp=1", br[1], mp[1]);
    else n_pass++;
    do_cycle();
  endtask

  task automatic test_bht_saturate();
    test_reset();
    drive(1, 4'b0110, 16'd9, 16'd9, 4'd7, 1, 0, 0);
    pred_idx = 4'd7;
    #1;
    n_checks++;
    if (pt[0] !== 1'b0) $display("FAIL bht_pre_update got %b want 0", pt[0]); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      do_cycle();
      n_checks++;
      if (pt[0] !== 1'b1 || mp[0] !== 1'b0)
        $display("FAIL bht_taken_%0d got pt=%b mp=%b want pt=1 mp=0", k, pt[0], mp[0]);
      else n_pass++;
    end
    drive(1, 4'b0110, 16'd9, 16'd8, 4'd7, 1, 0, 0);
    do_cycle();
    n_checks++;
    if (pt[0] !== 1'b1) $display("FAIL bht_sat_nt1 got %b want 1", pt[0]); else n_pass++;
    do_cycle();
    n_checks++;
    if (pt[0] !== 1'b0) $display("FAIL bht_sat_nt2 got %b want 0", pt[0]); else n_pass++;
    n_checks++;
    if (bc[0] !== 16'd5 || mc[0] !== 16'd2)
      $display("FAIL bht_counters got %0d/%0d want 5/2", bc[0], mc[0]);
    else n_pass++;
    drive(0, 4'b0000, 16'd0, 16'd0, 4'd0, 0, 0, 0);
    do_cycle();
  endtask

  task automatic test_stall_flush();
    int bc0;
    int mc0;
    bc0 = m_bc[0];
    mc0 = m_mc[0];
    drive(1, 4'b0111, 16'd3, 16'd4, 4'd2, 1, 0, 0);
    do_cycle();
    pred_idx = 4'd2;
    drive(1, 4'b0110, 16'd3, 16'd4, 4'd2, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      do_cycle();
      n_checks++;
      if (rv[0] !== 1'b1 || br[0] !== 2'b00 || mp[0] !== 1'b0)
        $display("FAIL stall_hold_%0d got v=%b br=%b mp=%b want v=1 br=00 mp=0", k, rv[0], br[0], mp[0]);
      else n_pass++;
      n_checks++;
      if (bc[0] !== 16'(bc0 + 1) || mc[0] !== 16'(mc0) || pt[0] !== 1'b1)
        $display("FAIL stall_state_%0d got %0d/%0d pt=%b want %0d/%0d pt=1", k, bc[0], mc[0], pt[0], bc0 + 1, mc0);
      else n_pass++;
    end
    flush = 1'b1;
    do_cycle();
    n_checks++;
    if (rv !== 2'b00) $display("FAIL flush_in_stall got %b want 00", rv); else n_pass++;
    n_checks++;
    if (bc[0] !== 16'(bc0 + 1)) $display("FAIL flush_counter got %0d want %0d", bc[0], bc0 + 1); else n_pass++;
    drive(0, 4'b0000, 16'd0, 16'd0, 4'd0, 0, 0, 0);
    do_cycle();
  endtask

  task automatic test_non_branch();
    int bc0;
    int mc0;
    bc0 = m_bc[0];
    mc0 = m_mc[0];
    drive(1, 4'b0000, 16'd7, 16'd7, 4'd3, 1, 0, 0);
    do_cycle();
    pred_idx = 4'd3;
    #1;
    n_checks++;
    if (rv[0] !== 1'b1 || br[0] !== 2'b01 || mp[0] !== 1'b0)
      $display("FAIL nonbranch_result got v=%b br=%b mp=%b want v=1 br=01 mp=0", rv[0], br[0], mp[0]);
    else n_pass++;
    n_checks++;
    if (bc[0] !== 16'(bc0) || mc[0] !== 16'(mc0))
      $display("FAIL nonbranch_counters got %0d/%0d want %0d/%0d", bc[0], mc[0], bc0, mc0);
    else n_pass++;
    n_checks++;
    if (pt[0] !== (m_bht[0][3] >= 2)) $display("FAIL nonbranch_bht got %b want %b", pt[0], m_bht[0][3] >= 2);
    else n_pass++;
    drive(0, 4'b0000, 16'd0, 16'd0, 4'd0, 0, 0, 0);
    do_cycle();
  endtask

  task automatic test_random();
    logic [15:0] pool [6];
    logic [3:0]  ops [6];
    logic [3:0]  op;
    pool[0] = 16'h0000; pool[1] = 16'h0001; pool[2] = 16'h0002;
    pool[3] = 16'hFFFF; pool[4] = 16'h8000; pool[5] = 16'h7FFF;
    ops[0] = 4'b0110; ops[1] = 4'b0111; ops[2] = 4'b0100;
    ops[3] = 4'b0101; ops[4] = 4'b1000; ops[5] = 4'b1001;
    for (int c = 0; c < 400; c++) begin
      op = ($urandom_range(0, 4) == 0) ? 4'($urandom) : ops[$urandom_range(0, 5)];
      drive($urandom_range(0, 4) != 0, op, pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)],
            4'($urandom_range(0, 15)), 1'($urandom), $urandom_range(0, 6) == 0, $urandom_range(0, 11) == 0);
      do_cycle();
      pred_idx = 4'($urandom_range(0, 15));
      #1;
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (rv[d] !== m_rv[d]) $display("FAIL rnd_res_valid c%0d dut%0d got %b want %b", c, d, rv[d], m_rv[d]);
        else n_pass++;
        if (m_rv[d]) begin
          n_checks++;
          if (br[d] !== 2'(m_brout[d]) || mp[d] !== m_mpout[d])
            $display("FAIL rnd_outcome c%0d dut%0d got br=%b mp=%b want br=%0d mp=%b", c, d, br[d], mp[d], m_brout[d], m_mpout[d]);
          else n_pass++;
        end
        n_checks++;
        if (bc[d] !== 16'(m_bc[d]) || mc[d] !== 16'(m_mc[d]))
          $display("FAIL rnd_counters c%0d dut%0d got %0d/%0d want %0d/%0d", c, d, bc[d], mc[d], m_bc[d], m_mc[d]);
        else n_pass++;
        n_checks++;
        if (pt[d] !== (m_bht[d][pred_idx] >= 2))
          $display("FAIL rnd_pred_taken c%0d dut%0d idx%0d got %b want %b", c, d, pred_idx, pt[d], m_bht[d][pred_idx] >= 2);
        else n_pass++;
      end
    end
    drive(0, 4'b0000, 16'd0, 16'd0, 4'd0, 0, 0, 0);
    do_cycle();
  endtask

  task automatic test_reset_midstream();
    for (int k = 0; k < 6; k++) begin
      drive(1, 4'b0110, 16'd1, 16'd1, 4'd3, 0, 0, 0);
      do_cycle();
    end
    #3;
    rst_n = 1'b0;
    mdl_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (rv[d] !== 1'b0 || br[d] !== 2'b01 || mp[d] !== 1'b0)
        $display("FAIL midreset_outputs dut%0d got v=%b br=%b mp=%b want v=0 br=01 mp=0", d, rv[d], br[d], mp[d]);
      else n_pass++;
      n_checks++;
      if (bc[d] !== 16'd0 || mc[d] !== 16'd0)
        $display("FAIL midreset_counters dut%0d got %0d/%0d want 0/0", d, bc[d], mc[d]);
      else n_pass++;
    end
    pred_idx = 4'd3;
    #1;
    n_checks++;
    if (pt !== 2'b00) $display("FAIL midreset_bht3 got %b want 00", pt); else n_pass++;
    drive(0, 4'b0000, 16'd0, 16'd0, 4'd0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_beq_directed();
  endtask

  initial begin
    test_reset();
    test_beq_directed();
    test_signed_cmp();
    test_bht_saturate();
    test_stall_flush();
    test_non_branch();
    test_random();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
